// File: rtl/tx_frame_ctrl_pkg.sv
// Shared types and defaults for the BPSK frame sequencer.
// Holds the FSM state encoding, symbol width/amplitude defaults and counter-width helpers.
package tx_pkg;
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_GUARD    = 2'd3
    } tx_state_e;

    localparam int                      SYM_W         = 16;
    localparam logic signed [SYM_W-1:0] AMP_DEF       = 16'sd16384;
    localparam int                      SPS_DEF       = 4;
    localparam int                      GUARD_LEN_DEF = 4;

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/tx_frame_ctrl_if.sv
// Payload handshake, transmitter drive/acknowledge and status bundle of the frame sequencer.
// master = the sequencer, slave = upstream source plus transmitter side.
interface tx_frame_ctrl_if #(parameter int DATA_W = 8);
    import tx_pkg::*;

    logic [DATA_W-1:0]       data_in;
    logic                    data_valid;
    logic                    data_ready;
    logic signed [SYM_W-1:0] bpsk_out;
    logic                    trans_start;
    logic                    trans_rdy;
    logic                    busy;
    logic                    frame_done;
    logic                    tx_err;

    modport master (
        input  data_in, data_valid, trans_rdy,
        output data_ready, bpsk_out, trans_start, busy, frame_done, tx_err
    );

    modport slave (
        output data_in, data_valid, trans_rdy,
        input  data_ready, bpsk_out, trans_start, busy, frame_done, tx_err
    );
endinterface

// File: rtl/tx_sym_timer.sv
// Sample counter 0..i_last with load/enable; o_sym_end marks the last sample of a symbol or guard span.
// o_sym_end is combinational from the count register, so it lines up with the cycle it describes.
module tx_sym_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_last,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sym_end
);
    logic [CNT_W-1:0] r_cnt;

    assign o_cnt     = r_cnt;
    assign o_sym_end = i_en && (r_cnt == i_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_sym_end ? '0 : r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/tx_frame_ctrl.sv
// BPSK frame sequencer: one word per frame, optional preamble (TX_PREAMBLE_EN), MSB-first +/-AMP symbols, guard gap.
// Latency 1 cycle from handshake to first symbol; payload is accepted only in IDLE, no buffering elsewhere.
module tx_frame_ctrl
    import tx_pkg::*;
#(
    parameter int                      DATA_W          = 8,
    parameter int                      SAMPLES_PER_SYM = SPS_DEF,
    parameter logic signed [SYM_W-1:0] AMP             = AMP_DEF,
    parameter int                      PRE_LEN         = 8,
    parameter int                      GUARD_LEN       = GUARD_LEN_DEF
) (
    input  logic           clk,
    input  logic           reset,
    tx_frame_ctrl_if.master bus
);
    localparam logic [1:0] S_IDLE     = ST_IDLE;
    localparam logic [1:0] S_PREAMBLE = ST_PREAMBLE;
    localparam logic [1:0] S_DATA     = ST_DATA;
    localparam logic [1:0] S_GUARD    = ST_GUARD;

`ifdef TX_PREAMBLE_EN
    localparam int PRE_ON = 1;
`else
    localparam int PRE_ON = 0;
`endif

    // The bit counter doubles as the preamble counter, so it is sized for the longer of the two.
    localparam int BIT_W = cnt_w(max2(DATA_W, PRE_ON * PRE_LEN));
    localparam int TMR_W = cnt_w(max2(SAMPLES_PER_SYM, GUARD_LEN));
    localparam logic [TMR_W-1:0] SYM_LAST = TMR_W'(SAMPLES_PER_SYM - 1);
    localparam logic [TMR_W-1:0] GRD_LAST = TMR_W'(GUARD_LEN - 1);

    logic [1:0]              r_state;
    logic [DATA_W-1:0]       r_shift;
    logic [BIT_W-1:0]        r_bit_cnt;
    logic                    r_data_ready;
    logic signed [SYM_W-1:0] r_bpsk;
    logic                    r_trans_start;
    logic                    r_busy;
    logic                    r_frame_done;
    logic                    r_tx_err;
    logic                    r_ts_prev;

    logic                    w_accept;
    logic                    w_to_guard;
    logic                    w_sym_end;
    logic [TMR_W-1:0]        w_cnt;
    logic [TMR_W-1:0]        w_last;

    function automatic logic signed [SYM_W-1:0] sym(input logic b);
        return b ? AMP : -AMP;
    endfunction

    assign w_accept   = (r_state == S_IDLE) && r_data_ready && bus.data_valid;
    assign w_to_guard = (r_state == S_DATA) && w_sym_end && (r_bit_cnt == BIT_W'(DATA_W - 1));
    assign w_last     = (r_state == S_GUARD) ? GRD_LAST : SYM_LAST;

    tx_sym_timer #(.CNT_W(TMR_W)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_accept || w_to_guard),
        .i_en      (r_state != S_IDLE),
        .i_last    (w_last),
        .o_cnt     (w_cnt),
        .o_sym_end (w_sym_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_data_ready  <= 1'b0;
            r_bpsk        <= '0;
            r_trans_start <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_tx_err      <= 1'b0;
            r_ts_prev     <= 1'b0;
        end else begin
            // r_ts_prev is cleared by reset, which suppresses the check right after reset.
            r_ts_prev    <= r_trans_start;
            if (r_ts_prev && !bus.trans_rdy) begin
                r_tx_err <= 1'b1;
            end
            r_frame_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift       <= bus.data_in;
                        r_bit_cnt     <= '0;
                        r_trans_start <= 1'b1;
                        r_data_ready  <= 1'b0;
                        r_busy        <= 1'b1;
`ifdef TX_PREAMBLE_EN
                        r_state       <= S_PREAMBLE;
                        r_bpsk        <= AMP;
`else
                        r_state       <= S_DATA;
                        r_bpsk        <= sym(bus.data_in[DATA_W-1]);
`endif
                    end else begin
                        r_data_ready  <= 1'b1;
                    end
                end
`ifdef TX_PREAMBLE_EN
                S_PREAMBLE: begin
                    if (w_sym_end) begin
                        if (r_bit_cnt == BIT_W'(PRE_LEN - 1)) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                            r_bpsk    <= sym(r_shift[DATA_W-1]);
                        end else begin
                            // Next preamble index is even (-> +AMP) exactly when the current one is odd.
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            r_bpsk    <= sym(r_bit_cnt[0]);
                        end
                    end
                end
`endif
                S_DATA: begin
                    if (w_sym_end) begin
                        if (w_to_guard) begin
                            r_state       <= S_GUARD;
                            r_bit_cnt     <= '0;
                            r_trans_start <= 1'b0;
                            r_bpsk        <= '0;
                            r_frame_done  <= (GUARD_LEN == 1);
                        end else begin
                            r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            r_bpsk    <= sym(r_shift[DATA_W-2]);
                        end
                    end
                end
                S_GUARD: begin
                    if (w_sym_end) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_data_ready <= 1'b1;
                    end else if (int'(w_cnt) == GUARD_LEN - 2) begin
                        r_frame_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.data_ready  = r_data_ready;
    assign bus.bpsk_out    = r_bpsk;
    assign bus.trans_start = r_trans_start;
    assign bus.busy        = r_busy;
    assign bus.frame_done  = r_frame_done;
    assign bus.tx_err      = r_tx_err;
endmodule
